// File: rtl/fetch_unit.sv
// Instruction fetch stage for the reverb/dereverb script sequencer.
// Drives the script-memory address and fills the IF/ID register one word per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | out of reset, waiting for start
// S_RUN  | fetching; PC advances on each consumed fetch
// S_HALT | script ended (halt word or last address); done held high
module fetch_unit #(
    parameter int             N          = 24,
    parameter int             DEPTH_BITS = 8,
    parameter logic [N-1:0]   HALT_WORD  = 24'hFFFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         script_sel,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic [N-1:0] instr_in,
    output logic         sel,
    output logic [N-1:0] address,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic         if_id_valid,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [DEPTH_BITS-1:0] PC_LAST = '1;

    state_t                state_q, state_d;
    logic [DEPTH_BITS-1:0] pc_q, pc_d;
    logic                  sel_q, sel_d;
    logic [N-1:0]          if_id_instr_q, if_id_instr_d;
    logic [DEPTH_BITS-1:0] if_id_pc_q, if_id_pc_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic                  done_q, done_d;

    logic                  unused_target_hi;
    assign unused_target_hi = ^branch_target[N-1:DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            sel_q         <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            sel_q         <= sel_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        sel_d         = sel_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        done_d        = done_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if_id_valid_d = 1'b0;
                if (start) begin
                    pc_d    = '0;
                    sel_d   = script_sel;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (branch_taken) begin
                    pc_d          = branch_target[DEPTH_BITS-1:0];
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    // A halt word is only acted on when the fetch is consumed
                    if (instr_in == HALT_WORD) begin
                        if_id_valid_d = 1'b0;
                        done_d        = 1'b1;
                        state_d       = S_HALT;
                    end else begin
                        if_id_instr_d = instr_in;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                        if (pc_q == PC_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel         = sel_q;
    assign address     = N'(pc_q);
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = N'(if_id_pc_q);
    assign if_id_valid = if_id_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, every cycle
// compared against a script-level model of the fetch behaviour.
module tb_fetch_unit;

    localparam logic [23:0] HALT = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        script_sel = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [23:0] branch_target = '0;
    logic [23:0] instr_in;
    logic        sel;
    logic [23:0] address;
    logic [23:0] if_id_instr;
    logic [23:0] if_id_pc;
    logic        if_id_valid;
    logic        done;

    logic [23:0] mem [0:1][0:255];

    int n_checks = 0;
    int n_err    = 0;

    // Model state: which script is loaded, where we are, what was last delivered
    bit          m_running;
    int          m_pc;
    bit          m_sel;
    logic [23:0] m_instr;
    int          m_ipc;
    bit          m_valid;
    bit          m_done;

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .script_sel(script_sel),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_in(instr_in), .sel(sel), .address(address),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .done(done)
    );

    always #5 clk = ~clk;

    assign instr_in = mem[sel][address[7:0]];

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [23:0] word;
        if (rst) begin
            m_running = 0; m_pc = 0; m_sel = 0;
            m_instr = '0; m_ipc = 0; m_valid = 0; m_done = 0;
        end else if (!m_running) begin
            m_valid = 0;
            if (start) begin
                m_pc = 0; m_sel = script_sel; m_done = 0; m_running = 1;
            end
        end else if (branch_taken) begin
            m_pc = int'(branch_target) % 256;
            m_valid = 0;
        end else if (!stall) begin
            word = mem[m_sel][m_pc];
            if (word == HALT) begin
                m_valid = 0; m_done = 1; m_running = 0;
            end else begin
                m_instr = word; m_ipc = m_pc; m_valid = 1;
                if (m_pc == 255) begin
                    m_done = 1; m_running = 0;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("address", address, 24'(m_pc));
        chk("sel", {23'd0, sel}, {23'd0, m_sel});
        chk("if_id_valid", {23'd0, if_id_valid}, {23'd0, m_valid});
        chk("done", {23'd0, done}, {23'd0, m_done});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, 24'(m_ipc));
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                mem[s][a] = 24'($urandom_range(0, 24'hFFFFFE));
        mem[1][0] = 24'h000011;
        mem[1][1] = 24'h000022;
        mem[0][7] = HALT;

        // reset
        rst = 1; start = 1; stall = 1; branch_taken = 1;
        cycle(); cycle();
        rst = 0; start = 0; stall = 0; branch_taken = 0;
        cycle();
        chk("reset_idle_address", address, 24'h0);

        // first two words of script 1
        start = 1; script_sel = 1;
        cycle();
        start = 0; script_sel = 0;
        chk("start_sel", {23'd0, sel}, 24'd1);
        cycle();
        chk("w0_instr", if_id_instr, 24'h000011);
        chk("w0_pc", if_id_pc, 24'h0);
        chk("w0_valid", {23'd0, if_id_valid}, 24'd1);
        cycle();
        chk("w1_instr", if_id_instr, 24'h000022);
        chk("w1_pc", if_id_pc, 24'h1);

        // stall at PC 5
        repeat (3) cycle();
        stall = 1;
        repeat (3) begin
            cycle();
            chk("stall_addr", address, 24'd5);
            chk("stall_ifpc", if_id_pc, 24'd4);
        end
        stall = 0;
        cycle();
        chk("resume_ifpc", if_id_pc, 24'd5);

        // branch beats stall at PC 9
        repeat (3) cycle();
        chk("pre_branch_addr", address, 24'd9);
        stall = 1; branch_taken = 1; branch_target = 24'h000040;
        cycle();
        stall = 0; branch_taken = 0;
        chk("branch_addr", address, 24'h40);
        chk("branch_bubble", {23'd0, if_id_valid}, 24'd0);
        cycle();
        chk("branch_word_pc", if_id_pc, 24'h40);
        chk("branch_word", if_id_instr, mem[1][64]);

        // reset mid-run at PC 0x30 with a branch pending
        branch_taken = 1; branch_target = 24'hAB0030;
        cycle();
        chk("pre_rst_addr", address, 24'h30);
        rst = 1; branch_target = 24'h000055;
        cycle();
        rst = 0; branch_taken = 0;
        chk("rst_instr", if_id_instr, 24'h0);
        chk("rst_done", {23'd0, done}, 24'd0);
        repeat (3) cycle();
        chk("idle_after_rst", address, 24'h0);

        // halt word at 7, stalled while it is presented
        start = 1; script_sel = 0;
        cycle();
        start = 0;
        repeat (7) cycle();
        stall = 1;
        repeat (2) cycle();
        chk("halt_ignored_in_stall", {23'd0, done}, 24'd0);
        stall = 0;
        cycle();
        chk("halt_done", {23'd0, done}, 24'd1);
        chk("halt_addr", address, 24'd7);
        chk("halt_last_pc", if_id_pc, 24'd6);
        stall = 1; branch_taken = 1; branch_target = 24'h12;
        repeat (2) cycle();
        stall = 0; branch_taken = 0;
        chk("halt_holds_addr", address, 24'd7);
        start = 1;
        cycle();
        start = 0;
        chk("restart_addr", address, 24'h0);
        chk("restart_done", {23'd0, done}, 24'd0);

        // full 256-word script without a halt word
        rst = 1; cycle(); rst = 0;
        start = 1; script_sel = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 300 && !done; i++) cycle();
        chk("full_done", {23'd0, done}, 24'd1);
        chk("full_last_pc", if_id_pc, 24'd255);
        chk("full_last_valid", {23'd0, if_id_valid}, 24'd1);
        chk("full_no_wrap", address, 24'd255);
        cycle();
        chk("full_after_valid", {23'd0, if_id_valid}, 24'd0);

        // random traffic
        for (int i = 0; i < 12; i++)
            mem[$urandom_range(0, 1)][$urandom_range(8, 255)] = HALT;
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            start         = ($urandom_range(0, 9) == 0);
            script_sel    = 1'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 24'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
